// File: rtl/mem_access_unit.sv
// MEM-stage load/store formatter: aligns accesses onto the data bus and extends load data.
// Optional macro MEM_SPLIT_MISALIGN_EN splits bus-word-crossing misaligned accesses into two beats.
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("mem_access_unit: DATA_W must be 32 or 64");
   end

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BEAT1 = 3'd1;
   localparam logic [2:0] S_WAIT1 = 3'd2;
   localparam logic [2:0] S_BEAT2 = 3'd3;
   localparam logic [2:0] S_WAIT2 = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              store_q, store_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rd_lo_q, rd_lo_d;
   logic [DATA_W-1:0] rd_hi_q, rd_hi_d;

   // Legality is decided on the incoming request so an illegal access never touches the bus.
   logic req_illegal;
   always_comb begin
      logic [3:0] req_amask;
      req_amask   = (4'd1 << req_size) - 4'd1;
`ifdef MEM_SPLIT_MISALIGN_EN
      req_illegal = (DATA_W == 32) && (req_size == 2'd3);
`else
      req_illegal = ((DATA_W == 32) && (req_size == 2'd3)) || (|(req_addr[3:0] & req_amask));
`endif
   end

   logic [LB-1:0]       off;
   logic [3:0]          nbytes;
   logic [2*NB-1:0]     be_base, be_full;
   logic [2*DATA_W-1:0] wd_full;
   logic [ADDR_W-1:0]   addr_al, addr_nx;
   logic                split;

   assign off     = addr_q[LB-1:0];
   assign nbytes  = 4'd1 << size_q;
   assign be_base = ((2*NB)'(1) << nbytes) - (2*NB)'(1);
   assign be_full = be_base << off;
   assign wd_full = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
   assign addr_al = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
   assign addr_nx = addr_al + ADDR_W'(NB);
`ifdef MEM_SPLIT_MISALIGN_EN
   assign split   = |be_full[2*NB-1:NB];
`else
   assign split   = 1'b0;
`endif

   // Both beats are concatenated before shifting so split loads merge for free.
   logic [2*DATA_W-1:0] rd_full;
   logic [DATA_W-1:0]   rd_shift, rd_mask, rd_ext;
   logic                sign_bit;

   assign rd_full  = {rd_hi_q, rd_lo_q} >> {off, 3'b000};
   assign rd_shift = rd_full[DATA_W-1:0];

   always_comb begin
      case (size_q)
         2'd0:    begin rd_mask = DATA_W'(8'hFF);         sign_bit = rd_shift[7];        end
         2'd1:    begin rd_mask = DATA_W'(16'hFFFF);      sign_bit = rd_shift[15];       end
         2'd2:    begin rd_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = rd_shift[31];       end
         default: begin rd_mask = '1;                     sign_bit = rd_shift[DATA_W-1]; end
      endcase
      rd_ext = (rd_shift & rd_mask) | ((sgn_q && sign_bit) ? ~rd_mask : '0);
   end

   // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_lo_d = rd_lo_q;
      rd_hi_d = rd_hi_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d = req_store;
               size_d  = req_size;
               sgn_d   = req_signed;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rd_lo_d = '0;
               rd_hi_d = '0;
               state_d = req_illegal ? S_ERR : S_BEAT1;
            end
         end
         S_BEAT1: begin
            if (bus_ack) begin
               if (store_q) begin
                  state_d = split ? S_BEAT2 : S_RESP;
               end else if (bus_rvalid) begin
                  rd_lo_d = bus_rdata;
                  state_d = split ? S_BEAT2 : S_RESP;
               end else begin
                  state_d = S_WAIT1;
               end
            end
         end
         S_WAIT1: begin
            if (bus_rvalid) begin
               rd_lo_d = bus_rdata;
               state_d = split ? S_BEAT2 : S_RESP;
            end
         end
         S_BEAT2: begin
            if (bus_ack) begin
               if (store_q) begin
                  state_d = S_RESP;
               end else if (bus_rvalid) begin
                  rd_hi_d = bus_rdata;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT2;
               end
            end
         end
         S_WAIT2: begin
            if (bus_rvalid) begin
               rd_hi_d = bus_rdata;
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         store_q <= 1'b0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_lo_q <= '0;
         rd_hi_q <= '0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_lo_q <= rd_lo_d;
         rd_hi_q <= rd_hi_d;
      end
   end

   logic in_beat1, in_beat2;
   assign in_beat1 = (state_q == S_BEAT1);
   assign in_beat2 = (state_q == S_BEAT2);

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
   assign rsp_err   = (state_q == S_ERR);
   assign rsp_rdata = ((state_q == S_RESP) && !store_q) ? rd_ext : '0;

   assign bus_req   = in_beat1 || in_beat2;
   assign bus_we    = bus_req && store_q;
   assign bus_addr  = in_beat1 ? addr_al : (in_beat2 ? addr_nx : '0);
   assign bus_be    = in_beat1 ? be_full[NB-1:0] : (in_beat2 ? be_full[2*NB-1:NB] : '0);
   assign bus_wdata = !store_q ? '0 :
                      in_beat1 ? wd_full[DATA_W-1:0] :
                      in_beat2 ? wd_full[2*DATA_W-1:DATA_W] : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance share clock and reset.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_req_valid, a_req_ready, a_req_store, a_req_signed;
   logic [1:0]  a_req_size;
   logic [31:0] a_req_addr, a_req_wdata;
   logic        a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;
   logic        a_bus_req, a_bus_we, a_bus_ack, a_bus_rvalid;
   logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
   logic [3:0]  a_bus_be;

   logic        b_req_valid, b_req_ready, b_req_store, b_req_signed;
   logic [1:0]  b_req_size;
   logic [31:0] b_req_addr;
   logic [63:0] b_req_wdata;
   logic        b_rsp_valid, b_rsp_err;
   logic [63:0] b_rsp_rdata;
   logic        b_bus_req, b_bus_we, b_bus_ack, b_bus_rvalid;
   logic [31:0] b_bus_addr;
   logic [63:0] b_bus_wdata, b_bus_rdata;
   logic [7:0]  b_bus_be;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(a_req_store),
      .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
      .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err), .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
      .bus_be(a_bus_be), .bus_wdata(a_bus_wdata), .bus_ack(a_bus_ack),
      .bus_rvalid(a_bus_rvalid), .bus_rdata(a_bus_rdata)
   );

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_store(b_req_store),
      .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err), .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
      .bus_be(b_bus_be), .bus_wdata(b_bus_wdata), .bus_ack(b_bus_ack),
      .bus_rvalid(b_bus_rvalid), .bus_rdata(b_bus_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled and inputs driven 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_a(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
      check("a_ready_before_req", a_req_ready, 1'b1);
      a_req_valid = 1'b1; a_req_store = st; a_req_size = sz;
      a_req_signed = sg; a_req_addr = ad; a_req_wdata = wd;
      tick();
      a_req_valid = 1'b0;
   endtask

   task automatic req_b(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [63:0] wd);
      check("b_ready_before_req", b_req_ready, 1'b1);
      b_req_valid = 1'b1; b_req_store = st; b_req_size = sz;
      b_req_signed = sg; b_req_addr = ad; b_req_wdata = wd;
      tick();
      b_req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_req_valid = 0; a_req_store = 0; a_req_size = 0; a_req_signed = 0;
      a_req_addr = 0; a_req_wdata = 0; a_bus_ack = 0; a_bus_rvalid = 0; a_bus_rdata = 0;
      b_req_valid = 0; b_req_store = 0; b_req_size = 0; b_req_signed = 0;
      b_req_addr = 0; b_req_wdata = 0; b_bus_ack = 0; b_bus_rvalid = 0; b_bus_rdata = 0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_ready", a_req_ready, 1'b1);
      check("rst_rsp_valid", a_rsp_valid, 1'b0);
      check("rst_rsp_err", a_rsp_err, 1'b0);
      check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
      check("rst_bus_req", a_bus_req, 1'b0);
      check("rst_bus_we", a_bus_we, 1'b0);
      check("rst_bus_addr", a_bus_addr, 32'h0);
      check("rst_bus_be", a_bus_be, 4'h0);
      check("rst_bus_wdata", a_bus_wdata, 32'h0);
      check("rst_b_ready", b_req_ready, 1'b1);

      // Signed byte load at 0x1003, zero-wait bus
      req_a(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
      check("lb_bus_req", a_bus_req, 1'b1);
      check("lb_bus_we", a_bus_we, 1'b0);
      check("lb_bus_addr", a_bus_addr, 32'h1000);
      check("lb_bus_be", a_bus_be, 4'h8);
      check("lb_ready_busy", a_req_ready, 1'b0);
      a_bus_ack = 1; a_bus_rvalid = 1; a_bus_rdata = 32'h8012_3456;
      tick();
      a_bus_ack = 0; a_bus_rvalid = 0;
      check("lb_rsp_valid", a_rsp_valid, 1'b1);
      check("lb_rsp_rdata", a_rsp_rdata, 32'hFFFF_FF80);
      check("lb_rsp_err", a_rsp_err, 1'b0);
      check("lb_bus_released", a_bus_req, 1'b0);
      tick();
      check("lb_rsp_one_cycle", a_rsp_valid, 1'b0);

      // Store half at 0x2002, immediate ack
      req_a(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD);
      check("sh_bus_we", a_bus_we, 1'b1);
      check("sh_bus_addr", a_bus_addr, 32'h2000);
      check("sh_bus_be", a_bus_be, 4'hC);
      check("sh_bus_wdata", a_bus_wdata, 32'hABCD_0000);
      a_bus_ack = 1;
      tick();
      a_bus_ack = 0;
      check("sh_rsp_valid", a_rsp_valid, 1'b1);
      check("sh_rsp_rdata", a_rsp_rdata, 32'h0);
      check("sh_rsp_err", a_rsp_err, 1'b0);
      tick();
      check("sh_rsp_one_cycle", a_rsp_valid, 1'b0);

      // Same store with ack delayed 3 cycles: request held 4 cycles
      req_a(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("shw_bus_req_%0d", i), a_bus_req, 1'b1);
         check($sformatf("shw_bus_be_%0d", i), a_bus_be, 4'hC);
         check($sformatf("shw_bus_wdata_%0d", i), a_bus_wdata, 32'hABCD_0000);
         check($sformatf("shw_no_rsp_%0d", i), a_rsp_valid, 1'b0);
         if (i == 3) a_bus_ack = 1;
         tick();
      end
      a_bus_ack = 0;
      check("shw_rsp_valid", a_rsp_valid, 1'b1);
      tick();

      // Unsigned half load at 0x10, rvalid two cycles after ack
      req_a(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      check("lhu_bus_be", a_bus_be, 4'h3);
      check("lhu_bus_addr", a_bus_addr, 32'h10);
      a_bus_ack = 1;
      tick();
      a_bus_ack = 0;
      check("lhu_wait_bus_req", a_bus_req, 1'b0);
      check("lhu_wait_ready", a_req_ready, 1'b0);
      check("lhu_wait_no_rsp", a_rsp_valid, 1'b0);
      tick();
      check("lhu_wait2_ready", a_req_ready, 1'b0);
      a_bus_rvalid = 1; a_bus_rdata = 32'h1234_F00D;
      tick();
      a_bus_rvalid = 0;
      check("lhu_rsp_valid", a_rsp_valid, 1'b1);
      check("lhu_rsp_rdata", a_rsp_rdata, 32'h0000_F00D);
      check("lhu_resp_ready", a_req_ready, 1'b0);
      tick();
      check("lhu_ready_after", a_req_ready, 1'b1);

      // Misaligned word load at 0x101
      req_a(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
`ifdef MEM_SPLIT_MISALIGN_EN
      check("lw_mis_beat1_req", a_bus_req, 1'b1);
      check("lw_mis_beat1_addr", a_bus_addr, 32'h100);
      check("lw_mis_beat1_be", a_bus_be, 4'hE);
      a_bus_ack = 1; a_bus_rvalid = 1; a_bus_rdata = 32'h3322_11AA;
      tick();
      check("lw_mis_beat2_req", a_bus_req, 1'b1);
      check("lw_mis_beat2_addr", a_bus_addr, 32'h104);
      check("lw_mis_beat2_be", a_bus_be, 4'h1);
      a_bus_rdata = 32'hBBCC_DD44;
      tick();
      a_bus_ack = 0; a_bus_rvalid = 0;
      check("lw_mis_rsp_valid", a_rsp_valid, 1'b1);
      check("lw_mis_rsp_err", a_rsp_err, 1'b0);
      check("lw_mis_rsp_rdata", a_rsp_rdata, 32'h4433_2211);
      tick();
`else
      check("lw_mis_rsp_valid", a_rsp_valid, 1'b1);
      check("lw_mis_rsp_err", a_rsp_err, 1'b1);
      check("lw_mis_rsp_rdata", a_rsp_rdata, 32'h0);
      check("lw_mis_no_bus", a_bus_req, 1'b0);
      tick();
      check("lw_mis_err_one_cycle", a_rsp_valid, 1'b0);
      check("lw_mis_still_no_bus", a_bus_req, 1'b0);
`endif

      // Dword size on the 32-bit instance is illegal
      req_a(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
      check("ld32_rsp_valid", a_rsp_valid, 1'b1);
      check("ld32_rsp_err", a_rsp_err, 1'b1);
      check("ld32_no_bus", a_bus_req, 1'b0);
      tick();

      // Reset while waiting for read data abandons the access
      req_a(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      a_bus_ack = 1;
      tick();
      a_bus_ack = 0;
      check("rstw_in_wait", a_req_ready, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_bus_req", a_bus_req, 1'b0);
      check("rstw_ready", a_req_ready, 1'b1);
      check("rstw_no_rsp", a_rsp_valid, 1'b0);
      a_bus_rvalid = 1; a_bus_rdata = 32'hDEAD_BEEF;
      tick();
      a_bus_rvalid = 0;
      check("rstw_stale_rvalid_ignored", a_rsp_valid, 1'b0);
      req_a(1'b0, 2'd2, 1'b1, 32'h40, 32'h0);
      check("rstw_new_addr", a_bus_addr, 32'h40);
      a_bus_ack = 1; a_bus_rvalid = 1; a_bus_rdata = 32'h1122_3344;
      tick();
      a_bus_ack = 0; a_bus_rvalid = 0;
      check("rstw_new_rsp_valid", a_rsp_valid, 1'b1);
      check("rstw_new_rdata", a_rsp_rdata, 32'h1122_3344);
      tick();

      // 64-bit: signed word load at 0x4
      req_b(1'b0, 2'd2, 1'b1, 32'h4, 64'h0);
      check("b_lw_bus_addr", b_bus_addr, 32'h0);
      check("b_lw_bus_be", b_bus_be, 8'hF0);
      b_bus_ack = 1; b_bus_rvalid = 1; b_bus_rdata = 64'h8000_0001_0000_0000;
      tick();
      b_bus_ack = 0; b_bus_rvalid = 0;
      check("b_lw_rsp_valid", b_rsp_valid, 1'b1);
      check("b_lw_rsp_rdata", b_rsp_rdata, 64'hFFFF_FFFF_8000_0001);
      tick();

      // 64-bit: unsigned word load keeps the upper half zero
      req_b(1'b0, 2'd2, 1'b0, 32'h4, 64'h0);
      b_bus_ack = 1; b_bus_rvalid = 1; b_bus_rdata = 64'h8000_0001_0000_0000;
      tick();
      b_bus_ack = 0; b_bus_rvalid = 0;
      check("b_lwu_rsp_rdata", b_rsp_rdata, 64'h0000_0000_8000_0001);
      tick();

      // 64-bit: signed dword load at 0x8
      req_b(1'b0, 2'd3, 1'b1, 32'h8, 64'h0);
      check("b_ld_bus_addr", b_bus_addr, 32'h8);
      check("b_ld_bus_be", b_bus_be, 8'hFF);
      b_bus_ack = 1; b_bus_rvalid = 1; b_bus_rdata = 64'h8877_6655_4433_2211;
      tick();
      b_bus_ack = 0; b_bus_rvalid = 0;
      check("b_ld_rsp_err", b_rsp_err, 1'b0);
      check("b_ld_rsp_rdata", b_rsp_rdata, 64'h8877_6655_4433_2211);
      tick();

      // 64-bit: byte store at 0x5
      req_b(1'b1, 2'd0, 1'b0, 32'h5, 64'h5A);
      check("b_sb_bus_we", b_bus_we, 1'b1);
      check("b_sb_bus_be", b_bus_be, 8'h20);
      check("b_sb_bus_wdata", b_bus_wdata, 64'h0000_5A00_0000_0000);
      b_bus_ack = 1;
      tick();
      b_bus_ack = 0;
      check("b_sb_rsp_valid", b_rsp_valid, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
